// File: rtl/cache_pkg.sv
// Shared definitions for the cache-side memory path: line/beat geometry
// and the state encoding of the cacheline adaptor.
package cache_pkg;

  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one 256-bit line request into a 4-beat 64-bit
// burst on the memory side. Read beats are assembled into the line buffer,
// write lines are serialised out of it, and one line_resp pulse marks
// completion. All outputs are decoded from registered state only, so an
// asynchronous reset drops the burst strobes immediately.
module cacheline_adaptor
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [31:0]       line_address,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [LINE_W-1:0] line_rdata,
  output logic              line_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [31:0]       burst_address,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  adaptor_state_t    state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [31:0]       addr_reg, addr_next;
  logic [LINE_W-1:0] buf_reg, buf_next;

  // Beat view of the line buffer; beat 0 is the least significant slice.
  logic [BEAT_W-1:0] beat_arr [BEATS];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat_arr[gi] = buf_reg[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  // State, beat counter, latched address and line buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      addr_reg  <= 32'd0;
      buf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      buf_reg   <= buf_next;
    end
  end

  // Next-state logic and burst/line handshake outputs.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    buf_next    = buf_reg;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    burst_wdata = '0;
    line_resp   = 1'b0;

    case (state_reg)
      IDLE: begin
        // Read has priority when both requests are raised together.
        if (line_read) begin
          addr_next  = {line_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          state_next = READ;
        end else if (line_write) begin
          addr_next  = {line_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          buf_next   = line_wdata;
          state_next = WRITE;
        end
      end

      READ: begin
        burst_read = 1'b1;
        if (burst_resp) begin
          buf_next[cnt_reg*BEAT_W +: BEAT_W] = burst_rdata;
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == LAST_BEAT) begin
            state_next = DONE;
          end
        end
      end

      WRITE: begin
        burst_write = 1'b1;
        burst_wdata = beat_arr[cnt_reg];
        if (burst_resp) begin
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == LAST_BEAT) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        line_resp  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign line_rdata    = buf_reg;
  assign burst_address = addr_reg;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed testbench for cacheline_adaptor: read, write, stalled beats,
// simultaneous/back-to-back requests, reset mid-read and spurious resps.
module tb_cacheline_adaptor;
  import cache_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              line_read;
  logic              line_write;
  logic [31:0]       line_address;
  logic [LINE_W-1:0] line_wdata;
  logic [LINE_W-1:0] line_rdata;
  logic              line_resp;
  logic              burst_read;
  logic              burst_write;
  logic [31:0]       burst_address;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;

  int checks;
  int failures;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_address (line_address),
    .line_wdata   (line_wdata),
    .line_rdata   (line_rdata),
    .line_resp    (line_resp),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_address(burst_address),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    line_read    = 1'b0;
    line_write   = 1'b0;
    line_address = 32'd0;
    line_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    #1;
    checks++; if (line_resp !== 1'b0) begin failures++; $display("FAIL rst_line_resp got=%0b exp=0", line_resp); end
    checks++; if (burst_read !== 1'b0) begin failures++; $display("FAIL rst_burst_read got=%0b exp=0", burst_read); end
    checks++; if (burst_write !== 1'b0) begin failures++; $display("FAIL rst_burst_write got=%0b exp=0", burst_write); end
    checks++; if (burst_address !== 32'd0) begin failures++; $display("FAIL rst_burst_address got=%h exp=0", burst_address); end
    checks++; if (burst_wdata !== 64'd0) begin failures++; $display("FAIL rst_burst_wdata got=%h exp=0", burst_wdata); end
    checks++; if (line_rdata !== 256'd0) begin failures++; $display("FAIL rst_line_rdata got=%h exp=0", line_rdata); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("txn reset: outputs cleared");
  endtask

  task automatic test_read();
    logic [63:0]  rd [4];
    logic [255:0] exp_line;
    rd[0] = 64'h1111_1111_1111_1111;
    rd[1] = 64'h2222_2222_2222_2222;
    rd[2] = 64'h3333_3333_3333_3333;
    rd[3] = 64'h4444_4444_4444_4444;
    exp_line = {rd[3], rd[2], rd[1], rd[0]};

    line_read    = 1'b1;
    line_address = 32'h0000_1234;
    tick();
    checks++; if (burst_read !== 1'b1) begin failures++; $display("FAIL read_accept burst_read got=%0b exp=1", burst_read); end
    checks++; if (burst_write !== 1'b0) begin failures++; $display("FAIL read_accept burst_write got=%0b exp=0", burst_write); end
    checks++; if (burst_address !== 32'h0000_1220) begin failures++; $display("FAIL read_addr got=%h exp=00001220", burst_address); end
    // Address input changes mid-transaction must not reach the burst side.
    line_address = 32'hFFFF_FFFF;
    repeat (3) begin
      tick();
      checks++; if (burst_read !== 1'b1 || line_resp !== 1'b0) begin failures++; $display("FAIL read_wait burst_read=%0b line_resp=%0b exp=1/0", burst_read, line_resp); end
    end
    for (int i = 0; i < 4; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = rd[i];
      tick();
      if (i < 3) begin
        checks++; if (line_resp !== 1'b0) begin failures++; $display("FAIL read_early_resp beat=%0d got=%0b exp=0", i, line_resp); end
      end
    end
    burst_resp  = 1'b0;
    burst_rdata = '0;
    checks++; if (line_resp !== 1'b1) begin failures++; $display("FAIL read_done line_resp got=%0b exp=1", line_resp); end
    checks++; if (burst_read !== 1'b0) begin failures++; $display("FAIL read_done burst_read got=%0b exp=0", burst_read); end
    checks++; if (line_rdata !== exp_line) begin failures++; $display("FAIL read_data got=%h exp=%h", line_rdata, exp_line); end
    checks++; if (burst_address !== 32'h0000_1220) begin failures++; $display("FAIL read_addr_stable got=%h exp=00001220", burst_address); end
    line_read = 1'b0;
    tick();
    checks++; if (line_resp !== 1'b0) begin failures++; $display("FAIL read_resp_pulse got=%0b exp=0", line_resp); end
    checks++; if (line_rdata !== exp_line) begin failures++; $display("FAIL read_data_hold got=%h exp=%h", line_rdata, exp_line); end
    $display("txn read addr=00001234 line=%h", line_rdata);
  endtask

  task automatic test_write();
    logic [63:0] wb [4];
    wb[0] = 64'hA0A0_A0A0_A0A0_A0A0;
    wb[1] = 64'hA1A1_A1A1_A1A1_A1A1;
    wb[2] = 64'hA2A2_A2A2_A2A2_A2A2;
    wb[3] = 64'hA3A3_A3A3_A3A3_A3A3;

    line_write   = 1'b1;
    line_address = 32'h8000_0040;
    line_wdata   = {wb[3], wb[2], wb[1], wb[0]};
    tick();
    checks++; if (burst_write !== 1'b1 || burst_read !== 1'b0) begin failures++; $display("FAIL write_accept burst_write=%0b burst_read=%0b exp=1/0", burst_write, burst_read); end
    checks++; if (burst_address !== 32'h8000_0040) begin failures++; $display("FAIL write_addr got=%h exp=80000040", burst_address); end
    line_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (burst_wdata !== wb[i]) begin failures++; $display("FAIL write_beat beat=%0d got=%h exp=%h", i, burst_wdata, wb[i]); end
      burst_resp = 1'b0;
      tick();
      checks++; if (burst_wdata !== wb[i] || burst_write !== 1'b1) begin failures++; $display("FAIL write_stall beat=%0d got=%h/%0b exp=%h/1", i, burst_wdata, burst_write, wb[i]); end
      burst_resp = 1'b1;
      tick();
      burst_resp = 1'b0;
    end
    checks++; if (line_resp !== 1'b1) begin failures++; $display("FAIL write_done line_resp got=%0b exp=1", line_resp); end
    checks++; if (burst_write !== 1'b0) begin failures++; $display("FAIL write_done burst_write got=%0b exp=0", burst_write); end
    line_write = 1'b0;
    tick();
    checks++; if (line_resp !== 1'b0 || burst_write !== 1'b0) begin failures++; $display("FAIL write_idle line_resp=%0b burst_write=%0b exp=0/0", line_resp, burst_write); end
    $display("txn write addr=80000040 beats=A0..A3");
  endtask

  task automatic test_stalled();
    logic [63:0]  rd [4];
    logic [255:0] exp_line;
    rd[0] = 64'h0123_4567_89AB_CDEF;
    rd[1] = 64'hFEDC_BA98_7654_3210;
    rd[2] = 64'h5555_AAAA_5555_AAAA;
    rd[3] = 64'h0F0F_F0F0_1234_8765;
    exp_line = {rd[3], rd[2], rd[1], rd[0]};

    line_read    = 1'b1;
    line_address = 32'h0000_0100;
    tick();
    for (int i = 0; i < 4; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = rd[i];
      tick();
      burst_resp  = 1'b0;
      burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      if (i < 3) begin
        tick();
        checks++; if (burst_read !== 1'b1 || line_resp !== 1'b0) begin failures++; $display("FAIL stall_gap beat=%0d burst_read=%0b line_resp=%0b exp=1/0", i, burst_read, line_resp); end
      end
    end
    checks++; if (line_resp !== 1'b1) begin failures++; $display("FAIL stall_done line_resp got=%0b exp=1", line_resp); end
    checks++; if (line_rdata !== exp_line) begin failures++; $display("FAIL stall_data got=%h exp=%h", line_rdata, exp_line); end
    line_read = 1'b0;
    tick();
    $display("txn stalled read addr=00000100 line=%h", line_rdata);
  endtask

  task automatic test_back_to_back();
    logic [63:0]  rd [4];
    logic [255:0] exp_line;
    rd[0] = 64'hC0C0_0000_0000_0001;
    rd[1] = 64'hC1C1_0000_0000_0002;
    rd[2] = 64'hC2C2_0000_0000_0003;
    rd[3] = 64'hC3C3_0000_0000_0004;
    exp_line = {rd[3], rd[2], rd[1], rd[0]};

    line_read    = 1'b1;
    line_write   = 1'b1;
    line_address = 32'h0000_0040;
    line_wdata   = {4{64'hBBBB_0000_CCCC_1111}};
    tick();
    checks++; if (burst_read !== 1'b1 || burst_write !== 1'b0) begin failures++; $display("FAIL simul_prio burst_read=%0b burst_write=%0b exp=1/0", burst_read, burst_write); end
    for (int i = 0; i < 4; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = rd[i];
      tick();
      checks++; if (burst_write !== 1'b0) begin failures++; $display("FAIL simul_no_write beat=%0d got=%0b exp=0", i, burst_write); end
    end
    burst_resp = 1'b0;
    checks++; if (line_resp !== 1'b1 || line_rdata !== exp_line) begin failures++; $display("FAIL simul_read_done line_resp=%0b data=%h exp=1/%h", line_resp, line_rdata, exp_line); end
    $display("txn simultaneous read addr=00000040 line=%h", line_rdata);
    // Arbiter switches to the pending write while the adaptor finishes.
    line_read = 1'b0;
    tick();
    checks++; if (burst_write !== 1'b0 || line_resp !== 1'b0) begin failures++; $display("FAIL b2b_idle burst_write=%0b line_resp=%0b exp=0/0", burst_write, line_resp); end
    tick();
    checks++; if (burst_write !== 1'b1) begin failures++; $display("FAIL b2b_start burst_write got=%0b exp=1", burst_write); end
    checks++; if (burst_wdata !== 64'hBBBB_0000_CCCC_1111) begin failures++; $display("FAIL b2b_wdata got=%h exp=bbbb0000cccc1111", burst_wdata); end
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      tick();
    end
    burst_resp = 1'b0;
    checks++; if (line_resp !== 1'b1) begin failures++; $display("FAIL b2b_write_done line_resp got=%0b exp=1", line_resp); end
    line_write = 1'b0;
    tick();
    $display("txn back-to-back write addr=00000040");
  endtask

  task automatic test_reset_mid_read();
    logic [63:0]  rd [4];
    logic [255:0] exp_line;
    rd[0] = 64'hE0E0_E0E0_0000_0000;
    rd[1] = 64'hE1E1_E1E1_1111_1111;
    rd[2] = 64'hE2E2_E2E2_2222_2222;
    rd[3] = 64'hE3E3_E3E3_3333_3333;
    exp_line = {rd[3], rd[2], rd[1], rd[0]};

    line_read    = 1'b1;
    line_address = 32'h0000_0200;
    tick();
    for (int i = 0; i < 2; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = 64'h9999_0000_0000_0000 | 64'(i);
      tick();
    end
    burst_resp = 1'b0;
    checks++; if (burst_read !== 1'b1) begin failures++; $display("FAIL rstmid_pre burst_read got=%0b exp=1", burst_read); end
    rst_n     = 1'b0;
    line_read = 1'b0;
    #1;
    checks++; if (burst_read !== 1'b0) begin failures++; $display("FAIL rstmid_async burst_read got=%0b exp=0", burst_read); end
    checks++; if (line_rdata !== 256'd0) begin failures++; $display("FAIL rstmid_buf got=%h exp=0", line_rdata); end
    repeat (2) begin
      tick();
      checks++; if (line_resp !== 1'b0) begin failures++; $display("FAIL rstmid_no_resp got=%0b exp=0", line_resp); end
    end
    rst_n = 1'b1;
    tick();
    checks++; if (line_resp !== 1'b0 || burst_read !== 1'b0) begin failures++; $display("FAIL rstmid_after line_resp=%0b burst_read=%0b exp=0/0", line_resp, burst_read); end
    line_read    = 1'b1;
    line_address = 32'h0000_031F;
    tick();
    checks++; if (burst_address !== 32'h0000_0300) begin failures++; $display("FAIL rstmid_addr got=%h exp=00000300", burst_address); end
    for (int i = 0; i < 4; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = rd[i];
      tick();
    end
    burst_resp = 1'b0;
    checks++; if (line_resp !== 1'b1 || line_rdata !== exp_line) begin failures++; $display("FAIL rstmid_reread line_resp=%0b data=%h exp=1/%h", line_resp, line_rdata, exp_line); end
    line_read = 1'b0;
    tick();
    $display("txn reset mid-read, reread addr=00000300 line=%h", line_rdata);
  endtask

  task automatic test_spurious_resp();
    logic [255:0] held;
    logic [63:0]  rd [4];
    logic [255:0] exp_line;
    held = {64'hE3E3_E3E3_3333_3333, 64'hE2E2_E2E2_2222_2222,
            64'hE1E1_E1E1_1111_1111, 64'hE0E0_E0E0_0000_0000};
    rd[0] = 64'h7000_0000_0000_0007;
    rd[1] = 64'h7100_0000_0000_0017;
    rd[2] = 64'h7200_0000_0000_0027;
    rd[3] = 64'h7300_0000_0000_0037;
    exp_line = {rd[3], rd[2], rd[1], rd[0]};

    burst_resp  = 1'b1;
    burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (2) begin
      tick();
      checks++; if (burst_read !== 1'b0 || burst_write !== 1'b0 || line_resp !== 1'b0) begin failures++; $display("FAIL spur_idle rd=%0b wr=%0b resp=%0b exp=0/0/0", burst_read, burst_write, line_resp); end
      checks++; if (line_rdata !== held) begin failures++; $display("FAIL spur_idle_data got=%h exp=%h", line_rdata, held); end
    end
    burst_resp = 1'b0;
    // A read after idle resps must still start at beat 0.
    line_read    = 1'b1;
    line_address = 32'h0000_0400;
    tick();
    for (int i = 0; i < 4; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = rd[i];
      tick();
    end
    checks++; if (line_resp !== 1'b1 || line_rdata !== exp_line) begin failures++; $display("FAIL spur_read line_resp=%0b data=%h exp=1/%h", line_resp, line_rdata, exp_line); end
    // burst_resp stays high through DONE with junk data.
    burst_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
    line_read   = 1'b0;
    tick();
    burst_resp = 1'b0;
    checks++; if (line_rdata !== exp_line) begin failures++; $display("FAIL spur_done_data got=%h exp=%h", line_rdata, exp_line); end
    checks++; if (line_resp !== 1'b0 || burst_read !== 1'b0) begin failures++; $display("FAIL spur_done_state line_resp=%0b burst_read=%0b exp=0/0", line_resp, burst_read); end
    $display("txn spurious resp, read addr=00000400 line=%h", line_rdata);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_read();
    test_write();
    test_stalled();
    test_back_to_back();
    test_reset_mid_read();
    test_spurious_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
